// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: write-back source
// indices, default capture steps and the writeback_select state encoding.
package mips_pkg;

  // Write-back source indices into src_data.
  localparam int unsigned SRC_ALU  = 0;
  localparam int unsigned SRC_MEM  = 1;
  localparam int unsigned SRC_LINK = 2;
  localparam int unsigned SRC_LUI  = 3;

  localparam int unsigned NSRC_DEFAULT  = 4;
  localparam int unsigned STEPW_DEFAULT = 4;

  // Capture step per source, entry 0 in the LSBs: ALU=7, MEM=9, LINK=7, LUI=8.
  localparam logic [NSRC_DEFAULT*STEPW_DEFAULT-1:0] STEPS_DEFAULT =
    {4'd8, 4'd7, 4'd9, 4'd7};

  // Last legal value of the shared step counter; reaching it unmatched is a timeout.
  localparam logic [STEPW_DEFAULT-1:0] LAST_STEP_DEFAULT = 4'd9;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_select.sv
// NSRC-way write-back source selector. Latches the source index, destination
// and write intent when an instruction starts, captures the chosen source once
// when the shared step counter reaches that source's step, and issues a
// registered one-cycle write strobe to the register file.
module writeback_select
  import mips_pkg::*;
#(
  parameter int unsigned                 WIDTH     = 32,
  parameter int unsigned                 NSRC      = NSRC_DEFAULT,
  parameter int unsigned                 STEPW     = STEPW_DEFAULT,
  parameter logic [NSRC*STEPW-1:0]       STEPS     = STEPS_DEFAULT,
  parameter logic [STEPW-1:0]            LAST_STEP = LAST_STEP_DEFAULT,
  localparam int unsigned                SELW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SELW-1:0]       sel,
  input  logic [4:0]            dst,
  input  logic                  regwrite,
  input  logic                  flush,
  input  logic [STEPW-1:0]      cont,
  input  logic [NSRC*WIDTH-1:0] src_data,
  output logic [WIDTH-1:0]      wb_data,
  output logic [4:0]            wb_addr,
  output logic                  wb_we,
  output logic                  busy,
  output logic                  err
);

  wb_state_e state_q, state_d;

  logic [SELW-1:0]  sel_q;
  logic [4:0]       dst_q;
  logic             regwrite_q;
  logic [WIDTH-1:0] wb_data_q;
  logic             wb_we_q;
  logic             err_q;

  // Unpack the flattened step table and source bus so they can be indexed by sel_q.
  logic [STEPW-1:0] step_arr [NSRC];
  logic [WIDTH-1:0] data_arr [NSRC];

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign step_arr[i] = STEPS[i*STEPW +: STEPW];
    assign data_arr[i] = src_data[i*WIDTH +: WIDTH];
  end

  logic sel_in_range;
  logic accept;
  logic reject;
  logic match;
  logic timeout;

  // Decode the events that drive both the state and the datapath registers.
  always_comb begin
    sel_in_range = (32'(sel) < NSRC);
    accept       = (state_q == StIdle) && start && sel_in_range;
    reject       = (state_q == StIdle) && start && !sel_in_range;
    // flush masks both the capture and the timeout; it has top priority in WAIT.
    match        = (state_q == StWait) && !flush && (cont == step_arr[sel_q]);
    timeout      = (state_q == StWait) && !flush && !match && (cont == LAST_STEP);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start while waiting is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (flush || match || timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Instruction context latched on an accepted start; held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      dst_q      <= '0;
      regwrite_q <= 1'b0;
    end else if (accept) begin
      sel_q      <= sel;
      dst_q      <= dst;
      regwrite_q <= regwrite;
    end
  end

  // Capture the selected source once; the strobe is high only in the cycle after a match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
    end else begin
      wb_we_q <= match && regwrite_q;
      if (match) begin
        wb_data_q <= data_arr[sel_q];
      end
    end
  end

  // Sticky error: bad source index on start or no capture by the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (reject || timeout) begin
      err_q <= 1'b1;
    end
  end

  // Output drive.
  always_comb begin
    busy    = (state_q == StWait);
    wb_data = wb_data_q;
    wb_addr = dst_q;
    wb_we   = wb_we_q;
    err     = err_q;
  end

endmodule

// File: tb/tb_writeback_select.sv
// Directed bench for writeback_select. The link source (index 2) is given an
// unreachable step so the timeout path can be exercised on the same instance.
module tb_writeback_select;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSRC  = 4;
  localparam int unsigned STEPW = 4;

  localparam logic [31:0] ALU_A = 32'h0000_002A;
  localparam logic [31:0] ALU_B = 32'h0000_0055;
  localparam logic [31:0] MEM_V = 32'hDEAD_BEEF;
  localparam logic [31:0] LNK_V = 32'h0040_0004;
  localparam logic [31:0] LUI_V = 32'h1234_0000;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [1:0]            sel;
  logic [4:0]            dst;
  logic                  regwrite;
  logic                  flush;
  logic [STEPW-1:0]      cont;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [WIDTH-1:0]      wb_data;
  logic [4:0]            wb_addr;
  logic                  wb_we;
  logic                  busy;
  logic                  err;

  int n_checks = 0;
  int n_errors = 0;

  writeback_select #(
    .WIDTH    (WIDTH),
    .NSRC     (NSRC),
    .STEPW    (STEPW),
    .STEPS    ({4'd8, 4'd10, 4'd9, 4'd7}),
    .LAST_STEP(4'd9)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sel     (sel),
    .dst     (dst),
    .regwrite(regwrite),
    .flush   (flush),
    .cont    (cont),
    .src_data(src_data),
    .wb_data (wb_data),
    .wb_addr (wb_addr),
    .wb_we   (wb_we),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive cont, advance one rising edge and settle.
  task automatic step(input logic [3:0] c);
    cont = c;
    @(posedge clk);
    #1;
  endtask

  // Issue a start with the given context while cont is 0.
  task automatic begin_instr(input logic [1:0] s, input logic [4:0] d, input logic rw);
    start    = 1'b1;
    sel      = s;
    dst      = d;
    regwrite = rw;
    step(4'd0);
    start = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    sel      = '0;
    dst      = '0;
    regwrite = 1'b0;
    flush    = 1'b0;
    cont     = '0;
    src_data = {LUI_V, LNK_V, MEM_V, ALU_A};
    #1;
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_addr", 32'(wb_addr), 32'h0);
    check("rst_wb_we", 32'(wb_we), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    step(4'd0);
    step(4'd0);
    rst_n = 1'b1;
    step(4'd0);

    // ALU source captured at step 7.
    begin_instr(2'd0, 5'd8, 1'b1);
    check("alu_busy_after_start", 32'(busy), 32'h1);
    for (int c = 1; c <= 6; c++) begin
      step(4'(c));
      check("alu_no_we_early", 32'(wb_we), 32'h0);
    end
    step(4'd7);
    check("alu_wb_data", wb_data, ALU_A);
    check("alu_wb_addr", 32'(wb_addr), 32'd8);
    check("alu_wb_we", 32'(wb_we), 32'h1);
    check("alu_busy_done", 32'(busy), 32'h0);
    step(4'd8);
    check("alu_we_one_cycle", 32'(wb_we), 32'h0);

    // Memory source: no capture at 7, capture at 9.
    begin_instr(2'd1, 5'd9, 1'b1);
    for (int c = 1; c <= 8; c++) step(4'(c));
    check("mem_busy_before", 32'(busy), 32'h1);
    check("mem_data_held", wb_data, ALU_A);
    check("mem_no_we_before", 32'(wb_we), 32'h0);
    step(4'd9);
    check("mem_wb_data", wb_data, MEM_V);
    check("mem_wb_addr", 32'(wb_addr), 32'd9);
    check("mem_wb_we", 32'(wb_we), 32'h1);
    check("mem_err_clear", 32'(err), 32'h0);
    step(4'd0);

    // Flush at step 8 aborts the memory capture.
    begin_instr(2'd1, 5'd10, 1'b1);
    for (int c = 1; c <= 7; c++) step(4'(c));
    flush = 1'b1;
    step(4'd8);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_no_we", 32'(wb_we), 32'h0);
    step(4'd9);
    check("flush_no_we_late", 32'(wb_we), 32'h0);
    check("flush_data_held", wb_data, MEM_V);
    check("flush_addr_latched", 32'(wb_addr), 32'd10);
    check("flush_no_err", 32'(err), 32'h0);

    // Flush coinciding with the ALU match wins.
    src_data[31:0] = ALU_B;
    begin_instr(2'd0, 5'd5, 1'b1);
    for (int c = 1; c <= 6; c++) step(4'(c));
    flush = 1'b1;
    step(4'd7);
    flush = 1'b0;
    check("flush_match_no_we", 32'(wb_we), 32'h0);
    check("flush_match_data", wb_data, MEM_V);
    check("flush_match_busy", 32'(busy), 32'h0);

    // regwrite=0: data captured without strobe; a start at the match edge is dropped.
    begin_instr(2'd0, 5'd11, 1'b0);
    for (int c = 1; c <= 6; c++) step(4'(c));
    start = 1'b1;
    sel   = 2'd3;
    dst   = 5'd3;
    step(4'd7);
    start = 1'b0;
    check("nowr_wb_data", wb_data, ALU_B);
    check("nowr_no_we", 32'(wb_we), 32'h0);
    check("nowr_busy", 32'(busy), 32'h0);
    step(4'd8);
    check("nowr_start_dropped", 32'(busy), 32'h0);
    check("nowr_addr", 32'(wb_addr), 32'd11);
    check("nowr_no_we_late", 32'(wb_we), 32'h0);

    // LUI source captured at step 8.
    begin_instr(2'd3, 5'd12, 1'b1);
    for (int c = 1; c <= 7; c++) step(4'(c));
    check("lui_no_we_early", 32'(wb_we), 32'h0);
    step(4'd8);
    check("lui_wb_data", wb_data, LUI_V);
    check("lui_wb_we", 32'(wb_we), 32'h1);
    check("lui_wb_addr", 32'(wb_addr), 32'd12);
    step(4'd0);

    // Link source has an unreachable step: timeout at 9 sets sticky err.
    begin_instr(2'd2, 5'd31, 1'b1);
    for (int c = 1; c <= 8; c++) step(4'(c));
    check("to_busy_before", 32'(busy), 32'h1);
    check("to_err_before", 32'(err), 32'h0);
    step(4'd9);
    check("to_err", 32'(err), 32'h1);
    check("to_busy", 32'(busy), 32'h0);
    check("to_no_we", 32'(wb_we), 32'h0);
    check("to_data_held", wb_data, LUI_V);
    step(4'd0);

    // err stays set across a later successful instruction.
    begin_instr(2'd0, 5'd4, 1'b1);
    for (int c = 1; c <= 6; c++) step(4'(c));
    step(4'd7);
    check("post_to_we", 32'(wb_we), 32'h1);
    check("post_to_data", wb_data, ALU_B);
    check("post_to_err_sticky", 32'(err), 32'h1);
    step(4'd0);

    // Asynchronous reset in the middle of WAIT.
    begin_instr(2'd1, 5'd20, 1'b1);
    step(4'd1);
    step(4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_wb_data", wb_data, 32'h0);
    check("arst_wb_addr", 32'(wb_addr), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    check("arst_wb_we", 32'(wb_we), 32'h0);
    step(4'd3);
    rst_n = 1'b1;
    for (int c = 4; c <= 9; c++) step(4'(c));
    check("arst_write_lost", 32'(wb_we), 32'h0);
    check("arst_stay_idle", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_select.md
# writeback_select

Parametrised writeback-source selector for the multicycle MIPS datapath. It generalises the two-way ALU/memory write-back mux to NSRC sources, each with its own capture step of the shared `cont` step counter. It latches the per-instruction selection, destination register and write intent at instruction start. It then captures the chosen source's data exactly once and presents a registered, one-cycle write strobe to the register bank. The block sits between the ALU/memory/PC stages and the register file.

## Interface
Parameters:
- WIDTH, 32, data width
- NSRC, 4, number of sources (0 ALU, 1 memory read data, 2 PC+4 link, 3 LUI immediate)
- STEPW, 4, width of `cont`
- STEPS, {4'd8,4'd7,4'd9,4'd7}, packed NSRC×STEPW capture step per source (entry 0 in LSBs); ALU=7, mem=9
- LAST_STEP, 4'd9, last legal step; timeout boundary

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  instruction start pulse
- sel  in  $clog2(NSRC)  source index, sampled on accepted start
- dst  in  5  destination register, sampled on accepted start
- regwrite  in  1  write intent, sampled on accepted start
- flush  in  1  abort current instruction
- cont  in  STEPW  shared multicycle step counter
- src_data  in  NSRC×WIDTH  flattened source data, source 0 in LSBs
- wb_data  out  WIDTH  captured write-back value (registered)
- wb_addr  out  5  latched destination
- wb_we  out  1  one-cycle register-file write strobe
- busy  out  1  high while WAIT
- err  out  1  sticky: sel out of range, or timeout

## Operation
- FSM states: IDLE, WAIT.
- IDLE + start: latch sel, dst, regwrite → WAIT. If sel ≥ NSRC: set err and stay IDLE.
- WAIT + flush: → IDLE. No capture, no strobe. flush has the highest priority.
- WAIT + (cont == STEPS[sel_q]): wb_data ← src_data[sel_q]; wb_we ← regwrite_q → IDLE.
- WAIT + (cont == LAST_STEP) without a match: set err → IDLE, no strobe.
- WAIT + start: ignored. Match and flush take precedence; the next start is accepted only in IDLE.
- wb_data holds its value between captures, including captures with regwrite_q=0.
- wb_addr holds the latched dst until the next accepted start.
- err clears only on reset.

## Timing
- Reset (async, rst_n low): state IDLE; wb_data=0, wb_addr=0, wb_we=0, busy=0, err=0; latched sel/dst/regwrite=0.
- start accepted at edge k: busy=1 from k.
- Match sampled at edge m: wb_data and wb_we valid after edge m; wb_we drops after edge m+1; busy=0 after m.
- A match can occur at the earliest in the cycle after the start edge, because cont is sampled only in WAIT.
- Simultaneous flush and match: flush wins, no write.
- Simultaneous start and match in WAIT: capture occurs, start is dropped.
- Reset mid-WAIT: immediate return to reset values; the pending write is lost.
- cont wrap-around (LAST_STEP→0) while WAIT is impossible, because the timeout fires at LAST_STEP.

## Structure
- Shared package `mips_pkg`: source index constants (SRC_ALU=0, SRC_MEM=1, SRC_LINK=2, SRC_LUI=3), default STEPS vector, LAST_STEP, and the state encoding.
- No sub-module. The NSRC:1 data mux and the step-compare are generate/index expressions in this file.

## Test plan
- Reset with rst_n low mid-cycle → all outputs 0 asynchronously; busy=0.
- start, sel=0, dst=8, regwrite=1, ALU=0x0000_002A; cont 0→7 → wb_data=0x2A, wb_addr=8, wb_we high exactly one cycle after the cont=7 edge.
- start, sel=1, mem=0xDEAD_BEEF, regwrite=1; cont reaches 7 → no capture; at cont=9 → wb_data=0xDEADBEEF, wb_we pulse.
- sel=1 with flush asserted at cont=8 → no wb_we; wb_data keeps its previous value; busy=0.
- sel=2 with STEPS overridden so the step is unreachable (e.g. 4'd10) → err=1 at the cont=9 edge, no wb_we; err persists across later starts.
- regwrite=0, sel=0 → wb_data updates at cont=7, wb_we stays 0. start pulse at cont=7 while busy → ignored, no second capture.
